config_stream_loader: RTL



---
 rtl/config_stream_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/config_stream_loader.sv
// Configuration bitstream master: fetches {addr,data} entries from the
// image memory and shifts them MSB-first into the config SRAM shifter.
module config_stream_loader #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int IMG_ADDR_BITS = 8,
  localparam int W            = ADDR_BITS + DATA_BITS
) (
  input  logic                     cclk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [IMG_ADDR_BITS:0]   word_count,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [IMG_ADDR_BITS-1:0] rd_addr,
  input  logic [W-1:0]             rd_data,
  output logic                     shift_enable,
  output logic                     shift_in,
  output logic                     config_set
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SHIFT, GAP1, SET, GAP2, DONE
  } state_t;

  state_t                 state;
  logic [IMG_ADDR_BITS:0] count;
  logic [IMG_ADDR_BITS:0] idx;
  logic [IMG_ADDR_BITS:0] idx_next;
  logic [W-1:0]           sreg;
  logic [CW-1:0]          bitcnt;

  // One bit wider than rd_addr so a full image ends without wrapping
  assign idx_next = idx + 1'b1;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      idx          <= '0;
      sreg         <= '0;
      bitcnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      shift_enable <= 1'b0;
      shift_in     <= 1'b0;
      config_set   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              count   <= word_count;
              idx     <= '0;
              rd_addr <= '0;
              rd_en   <= 1'b1;
              busy    <= 1'b1;
              state   <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          rd_en <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          // MSB goes straight to the pin; the rest waits in sreg
          shift_in     <= rd_data[W-1];
          sreg         <= {rd_data[W-2:0], 1'b0};
          shift_enable <= 1'b1;
          bitcnt       <= '0;
          state        <= SHIFT;
        end
        SHIFT: begin
          if (bitcnt == LAST) begin
            shift_enable <= 1'b0;
            shift_in     <= 1'b0;
            state        <= GAP1;
          end else begin
            shift_in <= sreg[W-1];
            sreg     <= {sreg[W-2:0], 1'b0};
            bitcnt   <= bitcnt + 1'b1;
          end
        end
        GAP1: begin
          config_set <= 1'b1;
          state      <= SET;
        end
        SET: begin
          config_set <= 1'b0;
          state      <= GAP2;
        end
        GAP2: begin
          idx <= idx_next;
          if (idx_next < count) begin
            rd_en   <= 1'b1;
            rd_addr <= idx_next[IMG_ADDR_BITS-1:0];
            state   <= FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
